// File: rtl/cpld_xnor_prbs_checker.sv
// Serial PRBS checker for XNOR-feedback LFSR streams (x^LEN + x^TAP + 1).
// Seeds from the stream, hunts for LOCK_CNT good predictions, then free-runs.
module cpld_xnor_prbs_checker #(
  parameter int LEN        = 7,
  parameter int TAP        = 6,
  parameter int LOCK_CNT   = 16,
  parameter int MISS_LIMIT = 4,
  parameter int WINDOW     = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        DIN,
  input  logic        CLR_CNT,
  output logic        LOCK,
  output logic        ERR,
  output logic [15:0] ERRCNT
);

  typedef enum logic [1:0] {
    SEED,
    HUNT,
    LOCKED
  } state_t;

  localparam logic [4:0]  SEED_LAST  = 5'(LEN - 1);
  localparam logic [7:0]  MATCH_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]  MISS_LAST  = 8'(MISS_LIMIT - 1);
  localparam logic [15:0] WIN_LAST   = 16'(WINDOW - 1);

  state_t         state_q, state_d;
  logic [LEN-1:0] s_q, s_d;
  logic [4:0]     seed_q, seed_d;
  logic [7:0]     match_q, match_d;
  logic [7:0]     miss_q, miss_d;
  logic [15:0]    win_q, win_d;
  logic [15:0]    errcnt_q, errcnt_d;
  logic           lock_q, lock_d;
  logic           err_q, err_d;

  logic pred;
  logic lockup;
  logic hunt_hit;
  logic lock_miss;
  logic win_wrap;

  always_comb begin
    pred      = s_q[LEN-1] ~^ s_q[TAP-1];
    // All-ones never occurs in an XNOR stream, so never accept it as a match
    lockup    = &s_q;
    hunt_hit  = (DIN == pred) && !lockup;
    lock_miss = (DIN != pred);
    win_wrap  = (win_q == WIN_LAST);

    state_d  = state_q;
    s_d      = s_q;
    seed_d   = seed_q;
    match_d  = match_q;
    miss_d   = miss_q;
    win_d    = win_q;
    errcnt_d = errcnt_q;
    err_d    = 1'b0;

    if (EN) begin
      unique case (state_q)
        SEED: begin
          s_d = {s_q[LEN-2:0], DIN};
          if (seed_q == SEED_LAST) begin
            state_d = HUNT;
            seed_d  = '0;
            match_d = '0;
          end else begin
            seed_d = seed_q + 5'd1;
          end
        end
        HUNT: begin
          s_d = {s_q[LEN-2:0], DIN};
          if (!hunt_hit) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            miss_d  = '0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        LOCKED: begin
          s_d   = {s_q[LEN-2:0], pred};
          win_d = win_wrap ? 16'd0 : win_q + 16'd1;
          if (win_wrap) begin
            miss_d = '0;
          end
          if (lock_miss) begin
            err_d = 1'b1;
            if (errcnt_q != 16'hFFFF) begin
              errcnt_d = errcnt_q + 16'd1;
            end
            // Loss of lock outranks a coincident window wrap
            if (miss_q == MISS_LAST) begin
              state_d = SEED;
              s_d     = '0;
              seed_d  = '0;
              win_d   = '0;
              miss_d  = '0;
            end else if (!win_wrap) begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = SEED;
        end
      endcase
    end

    if (CLR_CNT) begin
      errcnt_d = '0;
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SEED;
      s_q      <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      win_q    <= '0;
      errcnt_q <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      seed_q   <= seed_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      win_q    <= win_d;
      errcnt_q <= errcnt_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  assign LOCK   = lock_q;
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_cpld_xnor_prbs_checker.sv
// Scoreboard bench: stimulus queues expected outputs per clock edge,
// a negedge monitor pops and compares them against two checker instances.
module tb_cpld_xnor_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, din, clr;
  logic        lock, err;
  logic [15:0] errcnt;
  logic        rst_b, en_b, din_b, clr_b;
  logic        lock_b, err_b;
  logic [15:0] errcnt_b;

  int checks = 0;
  int errors = 0;
  int unsigned edge_n = 0;
  logic a_done = 1'b0;
  logic b_done = 1'b0;

  typedef struct {
    int unsigned edge_n;
    int          dut;
    logic        lock;
    logic        err;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  cpld_xnor_prbs_checker dut_a (
    .CLK(clk), .RST(rst), .EN(en), .DIN(din), .CLR_CNT(clr),
    .LOCK(lock), .ERR(err), .ERRCNT(errcnt)
  );

  cpld_xnor_prbs_checker #(
    .MISS_LIMIT(255), .WINDOW(256)
  ) dut_b (
    .CLK(clk), .RST(rst_b), .EN(en_b), .DIN(din_b), .CLR_CNT(clr_b),
    .LOCK(lock_b), .ERR(err_b), .ERRCNT(errcnt_b)
  );

  function automatic logic [6:0] gnext(input logic [6:0] g);
    return {g[5:0], g[6] ~^ g[5]};
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  exp_t        e;
  logic        al, ae;
  logic [15:0] ac;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n <= edge_n) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        al = lock; ae = err; ac = errcnt;
      end else begin
        al = lock_b; ae = err_b; ac = errcnt_b;
      end
      checks++;
      if (al !== e.lock || ae !== e.err || ac !== e.cnt) begin
        errors++;
        $display("FAIL %s: got lock=%0b err=%0b cnt=%h, want lock=%0b err=%0b cnt=%h",
                 e.tag, al, ae, ac, e.lock, e.err, e.cnt);
      end
    end
  end

  task automatic step_a(input logic r, input logic v, input logic d,
                        input logic c, input logic xl, input logic xe,
                        input logic [15:0] xc, input string tag);
    rst = r; en = v; din = d; clr = c;
    sb.push_back('{edge_n + 1, 0, xl, xe, xc, tag});
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic r, input logic v, input logic d,
                        input logic xl, input logic xe,
                        input logic [15:0] xc, input string tag);
    rst_b = r; en_b = v; din_b = d; clr_b = 1'b0;
    sb.push_back('{edge_n + 1, 1, xl, xe, xc, tag});
    @(posedge clk); #1;
  endtask

  // Main checker: clean lock, single errors, loss/relock, EN gaps, clear
  initial begin
    logic [6:0]  gen_a;
    logic [15:0] cnt;
    logic        inv, xl, c;
    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    gen_a = '0;
    cnt = '0;
    @(posedge clk); #1;
    step_a(1, 1, 1, 0, 0, 0, 0, "reset0");
    step_a(1, 0, 0, 0, 0, 0, 0, "reset1");
    for (int n = 1; n <= 1000; n++) begin
      gen_a = gnext(gen_a);
      inv = n inside {600, 700, 810, 812, 814, 816,
                      850, 860, 870, 910, 920, 930};
      if (inv) cnt = cnt + 16'd1;
      xl = (n >= 23 && n < 816) || n >= 839;
      step_a(0, 1, gen_a[0] ^ inv, 0, xl, inv, cnt,
             $sformatf("stream bit %0d", n));
    end
    step_a(1, 1, 0, 0, 0, 0, 0, "rst mid-lock");
    cnt = '0;
    for (int v = 1; v <= 100; v++) begin
      gen_a = gnext(gen_a);
      inv = v inside {60, 70, 75};
      c = (v == 70) || (v == 80);
      if (c) cnt = '0;
      else if (inv) cnt = cnt + 16'd1;
      xl = (v >= 23);
      step_a(0, 1, gen_a[0] ^ inv, c, xl, inv, cnt,
             $sformatf("gapped valid %0d", v));
      step_a(0, 0, 1'($urandom), 0, xl, 0, cnt,
             $sformatf("gap after %0d", v));
    end
    repeat (3) step_a(0, 0, 0, 0, 1, 0, cnt, "tail");
    a_done = 1'b1;
  end

  // Saturation checker: 254 errors per 256-bit window until past 16'hFFFF
  initial begin
    logic [6:0]  gen_b;
    logic        inv;
    int          nerr;
    int          j;
    logic [15:0] xc;
    rst_b = 1'b1; en_b = 1'b0; din_b = 1'b0; clr_b = 1'b0;
    gen_b = '0;
    @(posedge clk); #1;
    step_b(1, 0, 0, 0, 0, 0, "sat reset");
    for (int n = 1; n <= 23; n++) begin
      gen_b = gnext(gen_b);
      step_b(0, 1, gen_b[0], n >= 23, 0, 0, "sat acquire");
    end
    nerr = 0;
    j = 0;
    while (nerr < 65540) begin
      j++;
      gen_b = gnext(gen_b);
      inv = ((j - 1) % 256) < 254;
      if (inv) nerr++;
      xc = (nerr > 65535) ? 16'hFFFF : 16'(nerr);
      step_b(0, 1, gen_b[0] ^ inv, 1, inv, xc, "sat run");
    end
    b_done = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(a_done && b_done) && cyc < 80000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(a_done && b_done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: a_done=%0b b_done=%0b, want both 1", a_done, b_done);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
